// File: rtl/bcd_bin_conv_pkg.sv
// Shared constants, FSM state encoding and digit-validity helper for the
// BCD-to-binary converter.
package bcd_bin_conv_pkg;

  localparam int unsigned N_DIGITS = 3;
  localparam int unsigned BCD_W    = 12;
  localparam int unsigned BIN_W    = 10;
  localparam int unsigned N_STEPS  = 10;
  localparam int unsigned WORK_W   = BCD_W + BIN_W;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic has_bad_digit(input logic [BCD_W-1:0] bcd);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_bin_conv_sub3.sv
// Per-nibble correction for reverse double-dabble: nibbles of 8 or more
// lose 3 after each right shift.
module bcd_sub3 (
  input  logic [3:0] i_nib,
  output logic [3:0] o_nib
);

  always_comb begin
    o_nib = i_nib;
    if (i_nib >= 4'd8) o_nib = i_nib - 4'd3;
  end

endmodule

// File: rtl/bcd_bin_conv.sv
// Three-digit BCD to 10-bit binary converter using reverse double-dabble:
// 10 shift/correct steps over a {bcd, bin} work register.
module bcd_bin_conv
  import bcd_bin_conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BCD_W-1:0]  inBCD,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BIN_W-1:0]  outBin
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WORK_W-1:0]  r_work;
  logic               r_done;
  logic               r_err;
  logic [BIN_W-1:0]   r_outBin;

  logic [WORK_W-1:0]  w_shifted;
  logic [BCD_W-1:0]   w_bcd_fix;
  logic [WORK_W-1:0]  w_next;

  // Correction is applied to the post-shift nibbles in the same cycle.
  assign w_shifted = r_work >> 1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_sub3
    bcd_sub3 u_sub3 (
      .i_nib (w_shifted[BIN_W + 4*g +: 4]),
      .o_nib (w_bcd_fix[4*g +: 4])
    );
  end

  assign w_next = {w_bcd_fix, w_shifted[BIN_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_work   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_outBin <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work   <= {inBCD, {BIN_W{1'b0}}};
            r_cnt    <= '0;
            r_outBin <= '0;
            if (has_bad_digit(inBCD)) begin
              r_err   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 1'b0;
              r_state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          r_work <= w_next;
          if (r_cnt == CNT_W'(N_STEPS - 1)) begin
            r_outBin <= w_next[BIN_W-1:0];
            r_done   <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy   = (r_state == SHIFT);
  assign done   = r_done;
  assign err    = r_err;
  assign outBin = r_outBin;

endmodule

// File: tb/tb_bcd_bin_conv.sv
// Self-checking bench for bcd_bin_conv: directed cases, exhaustive valid
// sweep and random codes against a decimal-arithmetic reference.
module tb_bcd_bin_conv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] inBCD;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  outBin;

  int unsigned n_checks;
  int unsigned n_errors;

  bcd_bin_conv dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inBCD  (inBCD),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .outBin (outBin)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference: decimal value from the digits; any digit above 9 is invalid.
  function automatic void ref_model(input logic [11:0] bcd, output int val, output bit bad);
    int h, t, u;
    h = int'(bcd[11:8]);
    t = int'(bcd[7:4]);
    u = int'(bcd[3:0]);
    bad = (h > 9) || (t > 9) || (u > 9);
    val = bad ? 0 : (100 * h + 10 * t + u);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion: start accepted at cycle 0, then watch until done.
  task automatic do_conv(input logic [11:0] bcd, input string tag);
    int  val;
    bit  bad;
    int  n;
    int  busy_cnt;
    logic [9:0] held;
    ref_model(bcd, val, bad);
    tick();
    inBCD = bcd;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, ".latency"}, n, bad ? 1 : 11);
    check({tag, ".busycyc"}, busy_cnt, bad ? 0 : 10);
    check({tag, ".outBin"}, 32'(outBin), val);
    check({tag, ".err"}, 32'(err), 32'(bad));
    check({tag, ".busy_at_done"}, 32'(busy), 0);
    held = outBin;
    inBCD = 12'($urandom_range(4095, 0));
    tick();
    check({tag, ".done_drop"}, 32'(done), 0);
    check({tag, ".hold"}, 32'(outBin), 32'(held));
  endtask

  initial begin
    int pulses;
    logic [9:0] seen;
    n_checks = 0;
    n_errors = 0;
    rst   = 1'b1;
    start = 1'b0;
    inBCD = '0;
    tick();
    tick();
    check("reset.busy", 32'(busy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.err", 32'(err), 0);
    check("reset.outBin", 32'(outBin), 0);
    rst = 1'b0;

    do_conv(12'h999, "d999");
    do_conv(12'h000, "d000");
    do_conv(12'h509, "d509");
    do_conv(12'h1A5, "bad1A5");
    do_conv(12'h042, "d042");
    do_conv(12'hF00, "badF00");
    do_conv(12'h00A, "bad00A");

    // Start while busy must be ignored.
    tick();
    inBCD = 12'h123;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    inBCD = 12'h777;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    seen = '0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        pulses++;
        seen = outBin;
      end
      tick();
    end
    check("ignore.pulses", pulses, 1);
    check("ignore.outBin", 32'(seen), 123);
    check("ignore.idle_hold", 32'(outBin), 123);

    // Reset mid-conversion aborts with no done pulse.
    tick();
    inBCD = 12'h888;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 32'(busy), 0);
    check("abort.done", 32'(done), 0);
    check("abort.err", 32'(err), 0);
    check("abort.outBin", 32'(outBin), 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("abort.quiet", pulses, 0);
    do_conv(12'h100, "d100");

    // rst and start together: reset wins.
    inBCD = 12'h321;
    start = 1'b1;
    rst   = 1'b1;
    tick();
    start = 1'b0;
    rst   = 1'b0;
    check("rstwin.busy", 32'(busy), 0);
    check("rstwin.outBin", 32'(outBin), 0);
    tick();
    check("rstwin.busy2", 32'(busy), 0);

    // Exhaustive sweep over all valid codes.
    for (int h = 0; h < 10; h++)
      for (int t = 0; t < 10; t++)
        for (int u = 0; u < 10; u++)
          do_conv({4'(h), 4'(t), 4'(u)}, "sweep");

    // Random codes, valid and invalid mixed.
    for (int i = 0; i < 200; i++)
      do_conv(12'($urandom_range(4095, 0)), "rand");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bcd_bin_conv.md
BCD_BIN_CONV -- requirements
Module: bcd_bin_conv

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 inBCD  input  12  three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-007 done  output  1  one-cycle pulse when the result is valid.
REQ-008 err  output  1  high with done when any input digit is above 9; holds until the next accepted start.
REQ-009 outBin  output  10  binary result, 0..999; holds until the next accepted start.

Function
REQ-010 SHALL implement reverse double-dabble: this is the inverse of the binary-to-BCD add-3 converter.
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-012 IDLE + start=1 SHALL latch inBCD into a 22-bit work register {bcd[11:0], bin[9:0]}.
  - bin is cleared and the step counter is set to 0.
  - err and outBin are cleared.
  - FSM goes to SHIFT.
REQ-013 IDLE + start=1 with any inBCD digit above 9 SHALL go directly to DONE with err=1 and outBin=0.
REQ-014 Each SHIFT cycle SHALL do two things, in this order:
  - logically shift the 22-bit work register right by 1;
  - then, in the same cycle, subtract 3 from every BCD nibble whose post-shift value is 8 or more.
REQ-015 SHIFT SHALL run exactly 10 cycles (counter 0..9), then go to DONE; outBin is loaded from bin[9:0] on that transition.
REQ-016 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-017 Latency SHALL be fixed:
  - valid input: start accepted at cycle 0 -> done high at cycle 11;
  - invalid input: done high at cycle 1.
REQ-018 start SHALL be ignored while in SHIFT or DONE; the input is not queued.
REQ-019 In IDLE, inBCD changes without start SHALL have no effect.
REQ-020 busy SHALL equal (state == SHIFT).
REQ-021 After 10 steps the BCD field SHALL be zero for any valid input; no overflow is possible because 999 < 1024.

Reset
REQ-022 rst=1 SHALL force, on the next clock edge:
  - state IDLE, counter 0, work register 0;
  - busy=0, done=0, err=0, outBin=0.
REQ-023 rst during SHIFT or DONE SHALL abort the conversion with no done pulse.
REQ-024 When rst and start are both high in the same cycle, rst SHALL win.

Structure
REQ-025 A shared package SHALL hold:
  - constants N_DIGITS=3, BCD_W=12, BIN_W=10, N_STEPS=10;
  - the state encoding IDLE/SHIFT/DONE.
REQ-026 The per-nibble correction SHALL be a combinational sub-module bcd_sub3:
  - 4-bit in, 4-bit out;
  - out = in-3 when in >= 8, else in;
  - instantiated N_DIGITS times.

Verification
REQ-027 inBCD=0x999, start pulse -> done at cycle 11, outBin=999 (0x3E7), err=0, busy high on cycles 1..10.
REQ-028 inBCD=0x000 -> done at cycle 11, outBin=0; inBCD=0x509 -> outBin=509 (0x1FD).
REQ-029 inBCD=0x1A5 -> done at cycle 1, err=1, outBin=0; a following start with 0x042 -> err=0, outBin=42.
REQ-030 Start 0x123, then start=1 with 0x777 on cycle 5 -> only one done pulse, outBin=123.
REQ-031 Start 0x888, rst at cycle 4 -> no done pulse, all outputs 0; a new start with 0x100 -> outBin=100.
REQ-032 Exhaustive sweep over all 1000 valid codes -> outBin equals the decimal value every time, with 11-cycle latency.
